fp_mult: RTL and testbench
==========================

FP_MULT -- requirements
Module: fp_mult

Interface
REQ-001 Parameters: none; pipeline latency fixed at 5 enabled clocks.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 clk_en  input  1  pipeline advance enable; 0 freezes all pipeline registers.
REQ-005 dataa  input  32  IEEE-754 single-precision operand A.
REQ-006 datab  input  32  IEEE-754 single-precision operand B.
REQ-007 result  output  32  IEEE-754 single-precision product A*B, registered.

Function
REQ-008 SHALL implement a 5-stage pipeline; an operand pair sampled on an edge with clk_en=1 SHALL appear on result after the 5th enabled edge, counting the sampling edge.
REQ-009 clk_en=0 on an edge SHALL leave every stage, including result, unchanged; latency counts enabled edges only.
REQ-010 With clk_en held 1, a new pair SHALL be accepted every cycle; throughput 1 result per cycle.
REQ-011 Sign SHALL be sign(A) XOR sign(B) for all results, including zero and infinity; NaN sign is fixed as below.
REQ-012 Exponent SHALL be eA+eB-127 (10-bit signed intermediate), adjusted +1 when the 48-bit mantissa product is >= 2.0.
REQ-013 Mantissa: 24x24 unsigned multiply of hidden-bit significands, normalised to 24 bits, rounded round-to-nearest-even using guard and sticky (OR of all remaining bits).
REQ-014 Rounding carry-out SHALL renormalise (mantissa shifts right, exponent +1).
REQ-015 Denormal inputs (exp=0, frac!=0) SHALL be treated as signed zero (flush-to-zero).
REQ-016 Final exponent <= 0 SHALL produce signed zero (no denormal outputs).
REQ-017 Final exponent >= 255, including after rounding, SHALL produce signed infinity (exp=0xFF, frac=0).
REQ-018 Any NaN input, or infinity times zero/denormal, SHALL produce canonical NaN 0x7FC00000.
REQ-019 Infinity times finite nonzero or infinity SHALL produce signed infinity.
REQ-020 Zero times finite SHALL produce signed zero; special-case flags SHALL travel down the pipeline with their data.

Reset
REQ-021 reset=1 on a rising edge SHALL clear all pipeline registers and result to 0x00000000 regardless of clk_en.
REQ-022 Operations in flight at reset SHALL be discarded; no stale result SHALL appear afterwards.
REQ-023 After reset deasserts, outputs SHALL read 0x00000000 until the first post-reset operand pair emerges 5 enabled edges later.

Configuration
REQ-024 Macro FP_MULT_FLAGS_EN defined: SHALL add outputs overflow, underflow, zero, nan (1 bit each), registered and aligned with result, cleared by reset, frozen by clk_en=0.
REQ-025 overflow=1 when REQ-017 applies to finite inputs; underflow=1 when REQ-016 applies to a nonzero exact product; zero=1 when result is +-0; nan=1 when result is NaN.
REQ-026 Macro undefined: flag ports and their logic SHALL be absent; result behaviour identical.

Verification
REQ-027 0x40000000 * 0x40400000 (2.0*3.0), clk_en=1 -> result 0x40C00000 after 5 edges; 0xC0000000*0x40400000 -> 0xC0C00000.
REQ-028 Back-to-back pairs 1.5*1.5 (0x3FC00000) then 1.0*1.0 (0x3F800000) -> 0x40100000 then 0x3F800000 on consecutive cycles.
REQ-029 0x7F800000*0x00000000 -> 0x7FC00000 (nan=1); 0x7F000000*0x7F000000 -> 0x7F800000 (overflow=1); 0x00800000*0x00800000 -> 0x00000000 (underflow=1).
REQ-030 Issue 2.0*3.0, drop clk_en for 3 cycles after the 2nd edge -> result changes only on enabled edges; 0x40C00000 after the 5th enabled edge.
REQ-031 Reset asserted mid-pipeline with 3 ops in flight -> result 0x00000000 next edge and stays 0 until a new op completes.
REQ-032 Rounding: 0x3F800001*0x3F800001 -> 0x3F800002; denormal 0x00000001*0x3F800000 -> 0x00000000.

Source files
------------

// File: rtl/fp_mult.sv
// Five-stage IEEE-754 single-precision multiplier, flush-to-zero, round-to-nearest-even.
// Define FP_MULT_FLAGS_EN to add registered overflow/underflow/zero/nan status outputs.
module fp_mult (
  input  logic        clock,
  input  logic        reset,
  input  logic        clk_en,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result
`ifdef FP_MULT_FLAGS_EN
  ,
  output logic        overflow,
  output logic        underflow,
  output logic        zero,
  output logic        nan
`endif
);

  // Special-case bundle carried with each operation: {nan, inf, zero}.
  localparam int unsigned SpNan  = 2;
  localparam int unsigned SpInf  = 1;
  localparam int unsigned SpZero = 0;

  logic              s1_sign_q;
  logic [7:0]        s1_ea_q, s1_eb_q;
  logic [23:0]       s1_ma_q, s1_mb_q;
  logic [2:0]        s1_spec_q, s1_spec_d;

  logic              s2_sign_q;
  logic signed [9:0] s2_exp_q, s2_exp_d;
  logic [47:0]       s2_prod_q;
  logic [2:0]        s2_spec_q;

  logic              s3_sign_q;
  logic signed [9:0] s3_exp_q, s3_exp_d;
  logic [23:0]       s3_mant_q, s3_mant_d;
  logic              s3_guard_q, s3_guard_d, s3_sticky_q, s3_sticky_d;
  logic [2:0]        s3_spec_q;

  logic              s4_sign_q;
  logic signed [9:0] s4_exp_q, s4_exp_d;
  logic [22:0]       s4_frac_q, s4_frac_d;
  logic [2:0]        s4_spec_q;

  logic [31:0]       result_q, result_d;
  logic              ovf_d, unf_d;
  logic [24:0]       rounded;

  // Operand decode: exponent 0 covers both zero and denormal (flushed).
  always_comb begin
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    a_zero = (dataa[30:23] == 8'h00);
    b_zero = (datab[30:23] == 8'h00);
    a_inf  = (dataa[30:23] == 8'hFF) && (dataa[22:0] == 23'd0);
    b_inf  = (datab[30:23] == 8'hFF) && (datab[22:0] == 23'd0);
    a_nan  = (dataa[30:23] == 8'hFF) && (dataa[22:0] != 23'd0);
    b_nan  = (datab[30:23] == 8'hFF) && (datab[22:0] != 23'd0);
    s1_spec_d         = 3'b000;
    s1_spec_d[SpNan]  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
    s1_spec_d[SpInf]  = (a_inf | b_inf) & ~s1_spec_d[SpNan];
    s1_spec_d[SpZero] = (a_zero | b_zero) & ~s1_spec_d[SpNan];
  end

  assign s2_exp_d = $signed({2'b00, s1_ea_q}) + $signed({2'b00, s1_eb_q}) - 10'sd127;

  // Normalise: product in [1,4), take 24 bits below the leading one.
  always_comb begin
    if (s2_prod_q[47]) begin
      s3_mant_d   = s2_prod_q[47:24];
      s3_guard_d  = s2_prod_q[23];
      s3_sticky_d = |s2_prod_q[22:0];
      s3_exp_d    = s2_exp_q + 10'sd1;
    end else begin
      s3_mant_d   = s2_prod_q[46:23];
      s3_guard_d  = s2_prod_q[22];
      s3_sticky_d = |s2_prod_q[21:0];
      s3_exp_d    = s2_exp_q;
    end
  end

  always_comb begin
    rounded = {1'b0, s3_mant_q} + {24'd0, s3_guard_q & (s3_sticky_q | s3_mant_q[0])};
    if (rounded[24]) begin
      s4_frac_d = rounded[23:1];
      s4_exp_d  = s3_exp_q + 10'sd1;
    end else begin
      s4_frac_d = rounded[22:0];
      s4_exp_d  = s3_exp_q;
    end
  end

  always_comb begin
    result_d = {s4_sign_q, s4_exp_q[7:0], s4_frac_q};
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    if (s4_spec_q[SpNan]) begin
      result_d = 32'h7FC0_0000;
    end else if (s4_spec_q[SpInf]) begin
      result_d = {s4_sign_q, 8'hFF, 23'd0};
    end else if (s4_spec_q[SpZero]) begin
      result_d = {s4_sign_q, 31'd0};
    end else if (s4_exp_q <= 10'sd0) begin
      result_d = {s4_sign_q, 31'd0};
      unf_d    = 1'b1;
    end else if (s4_exp_q >= 10'sd255) begin
      result_d = {s4_sign_q, 8'hFF, 23'd0};
      ovf_d    = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_sign_q   <= 1'b0;
      s1_ea_q     <= '0;
      s1_eb_q     <= '0;
      s1_ma_q     <= '0;
      s1_mb_q     <= '0;
      s1_spec_q   <= '0;
      s2_sign_q   <= 1'b0;
      s2_exp_q    <= '0;
      s2_prod_q   <= '0;
      s2_spec_q   <= '0;
      s3_sign_q   <= 1'b0;
      s3_exp_q    <= '0;
      s3_mant_q   <= '0;
      s3_guard_q  <= 1'b0;
      s3_sticky_q <= 1'b0;
      s3_spec_q   <= '0;
      s4_sign_q   <= 1'b0;
      s4_exp_q    <= '0;
      s4_frac_q   <= '0;
      s4_spec_q   <= '0;
      result_q    <= '0;
`ifdef FP_MULT_FLAGS_EN
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      zero        <= 1'b0;
      nan         <= 1'b0;
`endif
    end else if (clk_en) begin
      s1_sign_q   <= dataa[31] ^ datab[31];
      s1_ea_q     <= dataa[30:23];
      s1_eb_q     <= datab[30:23];
      s1_ma_q     <= {1'b1, dataa[22:0]};
      s1_mb_q     <= {1'b1, datab[22:0]};
      s1_spec_q   <= s1_spec_d;
      s2_sign_q   <= s1_sign_q;
      s2_exp_q    <= s2_exp_d;
      s2_prod_q   <= s1_ma_q * s1_mb_q;
      s2_spec_q   <= s1_spec_q;
      s3_sign_q   <= s2_sign_q;
      s3_exp_q    <= s3_exp_d;
      s3_mant_q   <= s3_mant_d;
      s3_guard_q  <= s3_guard_d;
      s3_sticky_q <= s3_sticky_d;
      s3_spec_q   <= s2_spec_q;
      s4_sign_q   <= s3_sign_q;
      s4_exp_q    <= s4_exp_d;
      s4_frac_q   <= s4_frac_d;
      s4_spec_q   <= s3_spec_q;
      result_q    <= result_d;
`ifdef FP_MULT_FLAGS_EN
      overflow    <= ovf_d;
      underflow   <= unf_d;
      zero        <= (result_d[30:0] == 31'd0);
      nan         <= s4_spec_q[SpNan];
`endif
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_fp_mult.sv
// Directed self-checking bench for fp_mult: arithmetic, specials, rounding, clk_en and reset.
module tb_fp_mult;

  logic        clock = 1'b0;
  logic        reset, clk_en;
  logic [31:0] dataa, datab, result;
`ifdef FP_MULT_FLAGS_EN
  logic        overflow, underflow, zero, nan;
`endif
  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  fp_mult dut (
    .clock  (clock),
    .reset  (reset),
    .clk_en (clk_en),
    .dataa  (dataa),
    .datab  (datab),
    .result (result)
`ifdef FP_MULT_FLAGS_EN
    ,
    .overflow  (overflow),
    .underflow (underflow),
    .zero      (zero),
    .nan       (nan)
`endif
  );

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; clk_en = 1'b0;
    dataa = 32'h4000_0000; datab = 32'h4040_0000;
    tick();
    checks++;
    if (result !== 32'h0) begin
      errors++; $display("FAIL reset_clear: result=%h expected=00000000", result);
    end
    // 2.0*3.0 held on the inputs: zero for 4 edges, product on the 5th.
    reset = 1'b0; clk_en = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (result !== ((c == 4) ? 32'h40C0_0000 : 32'h0)) begin
        errors++; $display("FAIL reset_release[%0d]: result=%h", c, result);
      end
    end
    dataa = 32'h0; datab = 32'h0;
    for (int c = 0; c < 4; c++) tick();
  endtask

  task automatic test_arith();
    logic [31:0] va [7] = '{32'h4000_0000, 32'hC000_0000, 32'h3F80_0001, 32'h3F80_0001,
                            32'h3F80_0003, 32'h3FA1_E58F, 32'hBF80_0000};
    logic [31:0] vb [7] = '{32'h4040_0000, 32'h4040_0000, 32'h3F80_0001, 32'h3FC0_0000,
                            32'h3FC0_0000, 32'h3FCA_6691, 32'hBF80_0000};
    logic [31:0] ve [7] = '{32'h40C0_0000, 32'hC0C0_0000, 32'h3F80_0002, 32'h3FC0_0002,
                            32'h3FC0_0004, 32'h4000_0000, 32'h3F80_0000};
    clk_en = 1'b1;
    for (int c = 0; c < 11; c++) begin
      if (c < 7) begin dataa = va[c]; datab = vb[c]; end
      else begin dataa = 32'h0; datab = 32'h0; end
      tick();
      if (c >= 4) begin
        checks++;
        if (result !== ve[c-4]) begin
          errors++; $display("FAIL arith[%0d]: result=%h expected=%h", c - 4, result, ve[c-4]);
        end
      end
    end
  endtask

  task automatic test_special();
    logic [31:0] va [13] = '{32'h7F80_0000, 32'h7F00_0000, 32'h0080_0000, 32'h0000_0001,
                             32'h7FC0_0001, 32'h7F80_0000, 32'h8000_0000, 32'hFF80_0000,
                             32'h7F21_E58F, 32'h0080_0000, 32'h0080_0000, 32'h8000_0001,
                             32'h7F80_0000};
    logic [31:0] vb [13] = '{32'h0000_0000, 32'h7F00_0000, 32'h0080_0000, 32'h3F80_0000,
                             32'h3F80_0000, 32'hC000_0000, 32'h4040_0000, 32'hFF80_0000,
                             32'h3FCA_6691, 32'h3F80_0000, 32'h3F00_0000, 32'h3F80_0000,
                             32'h0000_0001};
    logic [31:0] ve [13] = '{32'h7FC0_0000, 32'h7F80_0000, 32'h0000_0000, 32'h0000_0000,
                             32'h7FC0_0000, 32'hFF80_0000, 32'h8000_0000, 32'h7F80_0000,
                             32'h7F80_0000, 32'h0080_0000, 32'h0000_0000, 32'h8000_0000,
                             32'h7FC0_0000};
`ifdef FP_MULT_FLAGS_EN
    // {overflow, underflow, zero, nan}
    logic [3:0]  vf [13] = '{4'b0001, 4'b1000, 4'b0110, 4'b0010, 4'b0001, 4'b0000, 4'b0010,
                             4'b0000, 4'b1000, 4'b0000, 4'b0110, 4'b0010, 4'b0001};
`endif
    clk_en = 1'b1;
    for (int c = 0; c < 17; c++) begin
      if (c < 13) begin dataa = va[c]; datab = vb[c]; end
      else begin dataa = 32'h0; datab = 32'h0; end
      tick();
      if (c >= 4) begin
        checks++;
        if (result !== ve[c-4]) begin
          errors++; $display("FAIL special[%0d]: result=%h expected=%h", c - 4, result, ve[c-4]);
        end
`ifdef FP_MULT_FLAGS_EN
        checks++;
        if ({overflow, underflow, zero, nan} !== vf[c-4]) begin
          errors++;
          $display("FAIL flags[%0d]: flags=%b expected=%b", c - 4,
                   {overflow, underflow, zero, nan}, vf[c-4]);
        end
`endif
      end
    end
  endtask

  task automatic test_back_to_back();
    clk_en = 1'b1;
    dataa = 32'h3FC0_0000; datab = 32'h3FC0_0000; tick();
    dataa = 32'h3F80_0000; datab = 32'h3F80_0000; tick();
    dataa = 32'h0; datab = 32'h0;
    for (int c = 0; c < 3; c++) tick();
    checks++;
    if (result !== 32'h4010_0000) begin
      errors++; $display("FAIL b2b_first: result=%h expected=40100000", result);
    end
    tick();
    checks++;
    if (result !== 32'h3F80_0000) begin
      errors++; $display("FAIL b2b_second: result=%h expected=3f800000", result);
    end
    for (int c = 0; c < 4; c++) tick();
  endtask

  task automatic test_clk_en();
    reset = 1'b1; tick(); reset = 1'b0;
    clk_en = 1'b1; dataa = 32'h4000_0000; datab = 32'h4040_0000; tick();
    dataa = 32'h0; datab = 32'h0; tick();
    // Frozen edges: these operands must never be sampled.
    clk_en = 1'b0; dataa = 32'h3F80_0000; datab = 32'h3F80_0000;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (result !== 32'h0) begin
        errors++; $display("FAIL clk_en_frozen[%0d]: result=%h expected=00000000", c, result);
      end
    end
    clk_en = 1'b1; dataa = 32'h0; datab = 32'h0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (result !== ((c == 2) ? 32'h40C0_0000 : 32'h0)) begin
        errors++; $display("FAIL clk_en_resume[%0d]: result=%h", c, result);
      end
    end
    clk_en = 1'b0; dataa = 32'h3F80_0000; datab = 32'h3F80_0000;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (result !== 32'h40C0_0000) begin
        errors++; $display("FAIL clk_en_hold[%0d]: result=%h expected=40c00000", c, result);
      end
    end
    clk_en = 1'b1; dataa = 32'h0; datab = 32'h0;
    tick();
    checks++;
    if (result !== 32'h0) begin
      errors++; $display("FAIL clk_en_next: result=%h expected=00000000", result);
    end
    for (int c = 0; c < 4; c++) tick();
  endtask

  task automatic test_reset_midflight();
    clk_en = 1'b1;
    dataa = 32'h4000_0000; datab = 32'h4040_0000; tick();
    dataa = 32'h3FC0_0000; datab = 32'h3FC0_0000; tick();
    dataa = 32'h3F80_0000; datab = 32'h3F80_0000; tick();
    reset = 1'b1; tick();
    checks++;
    if (result !== 32'h0) begin
      errors++; $display("FAIL midflight_reset: result=%h expected=00000000", result);
    end
    reset = 1'b0; dataa = 32'h0; datab = 32'h0;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (result !== 32'h0) begin
        errors++; $display("FAIL midflight_stale[%0d]: result=%h expected=00000000", c, result);
      end
    end
    // Reset must win while clk_en is low.
    dataa = 32'h4000_0000; datab = 32'h4040_0000;
    for (int c = 0; c < 5; c++) tick();
    checks++;
    if (result !== 32'h40C0_0000) begin
      errors++; $display("FAIL reset_en0_pre: result=%h expected=40c00000", result);
    end
    clk_en = 1'b0; reset = 1'b1; tick();
    checks++;
    if (result !== 32'h0) begin
      errors++; $display("FAIL reset_en0: result=%h expected=00000000", result);
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clk_en = 1'b0; dataa = 32'h0; datab = 32'h0;
    @(negedge clock);
    test_reset();
    test_arith();
    test_special();
    test_back_to_back();
    test_clk_en();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
